// File: rtl/genius_seq_engine.sv
// genius_seq_engine: Simon-game sequence generator, LED playback and player-press checker
module genius_seq_engine #(
  parameter int N_BTN = 4,
  parameter int MAX_LEN = 16,
  parameter int PW = 8,
  parameter int ON_TICKS = 2,
  parameter int OFF_TICKS = 1,
  parameter int TIMEOUT_TICKS = 8,
  localparam int SYM_W = $clog2(N_BTN),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic             tick,
  input  logic [LW-1:0]    target_len,
  input  logic [15:0]      seed,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] leds,
  output logic [LW-1:0]    round,
  output logic [PW-1:0]    points,
  output logic             show,
  output logic             user,
  output logic             match,
  output logic             win,
  output logic             lose
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CA = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
  localparam int CMAX = CA > TIMEOUT_TICKS ? CA : TIMEOUT_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = (PW > LW ? PW : LW) + 1;
  typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, USER, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [15:0] lfsr, lfsr_nx;
  logic [SYM_W-1:0] mem [MAX_LEN];
  logic [LW-1:0] pp, up, target;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;
  logic [PW-1:0] sat;
  logic [N_BTN-1:0] exp_oh;
  logic press, hit, last, on_done, off_done, tmo;
  assign lfsr_nx = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
  assign exp_oh = N_BTN'(1) << mem[up[AW-1:0]];
  assign press = state == USER && |btn;
  assign hit = press && btn == exp_oh;
  assign last = hit && up + LW'(1) == round;
  assign on_done = state == SHOW_ON && tick && cnt == CW'(ON_TICKS - 1);
  assign off_done = state == SHOW_OFF && tick && cnt == CW'(OFF_TICKS - 1);
  // a press in the same cycle as the final timeout tick takes precedence
  assign tmo = state == USER && !press && tick && cnt == CW'(TIMEOUT_TICKS - 1);
  assign sum = SW'(points) + SW'(round);
  assign sat = sum > SW'({PW{1'b1}}) ? {PW{1'b1}} : sum[PW-1:0];
  always_ff @(posedge clk or posedge R)
    if (R) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (start) state_n = ADD;
    else
      case (state)
        ADD:      state_n = SHOW_ON;
        SHOW_ON:  state_n = on_done ? SHOW_OFF : SHOW_ON;
        SHOW_OFF: state_n = !off_done ? SHOW_OFF : pp + LW'(1) == round ? USER : SHOW_ON;
        USER:     state_n = (press && !hit) || tmo ? LOSE : !last ? USER : round == target ? WIN : ADD;
        default:  state_n = state;
      endcase
  end
  always_comb begin
    leds = state == SHOW_ON ? N_BTN'(1) << mem[pp[AW-1:0]] : '0;
    show = state == SHOW_ON || state == SHOW_OFF;
    user = state == USER;
    win = state == WIN;
    lose = state == LOSE;
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      lfsr <= 16'hACE1;
      round <= '0;
      points <= '0;
      target <= '0;
      pp <= '0;
      up <= '0;
      cnt <= '0;
      match <= 1'b0;
    end else begin
      match <= hit && !start;
      if (start) begin
        lfsr <= seed == '0 ? 16'hACE1 : seed;
        round <= '0;
        points <= '0;
        cnt <= '0;
        target <= target_len == '0 || target_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : target_len;
      end else if (state == ADD) begin
        lfsr <= lfsr_nx;
        round <= round + LW'(1);
        pp <= '0;
        cnt <= '0;
      end else if (on_done || off_done) begin
        cnt <= '0;
        pp <= pp + LW'(off_done);
        up <= '0;
      end else if (hit) begin
        up <= up + LW'(1);
        cnt <= '0;
        if (last) points <= sat;
      end else if (tick && (show || user))
        cnt <= cnt + CW'(1);
    end
  always_ff @(posedge clk)
    if (state == ADD && !start) mem[round[AW-1:0]] <= lfsr_nx[SYM_W-1:0];
endmodule

// File: tb/tb_genius_seq_engine.sv
// tb_genius_seq_engine: directed game scenarios scored against a bench-side LFSR/points model
module tb_genius_seq_engine;
  localparam int NB = 4, ML = 16, LW = 5, ON = 2, OFF = 1, TO = 8;
  logic clk = 1'b0, R = 1'b1, start = 1'b0, tick = 1'b0;
  logic [LW-1:0] target_len = '0;
  logic [15:0] seed = '0;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] leds, leds4;
  logic [LW-1:0] round, round4;
  logic [7:0] points;
  logic [3:0] points4;
  logic show, user, match, win, lose, show4, user4, match4, win4, lose4;
  int n_err = 0, n_chk = 0;
  logic [15:0] m_lfsr;
  int seq[$];
  int m_round, m_pts, m_pts4;
  logic [NB-1:0] q_leds[$];
  logic q_match[$];
  genius_seq_engine #(.N_BTN(NB), .MAX_LEN(ML), .PW(8), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)) u8 (
    .clk(clk), .R(R), .start(start), .tick(tick), .target_len(target_len), .seed(seed), .btn(btn),
    .leds(leds), .round(round), .points(points), .show(show), .user(user), .match(match), .win(win), .lose(lose));
  genius_seq_engine #(.N_BTN(NB), .MAX_LEN(ML), .PW(4), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)) u4 (
    .clk(clk), .R(R), .start(start), .tick(tick), .target_len(target_len), .seed(seed), .btn(btn),
    .leds(leds4), .round(round4), .points(points4), .show(show4), .user(user4), .match(match4), .win(win4), .lose(lose4));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask
  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction
  task automatic new_game(input logic [15:0] s, input int tl);
    seed = s;
    target_len = LW'(tl);
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_lfsr = s == 16'h0 ? 16'hACE1 : s;
    seq.delete();
    m_round = 0;
    m_pts = 0;
    m_pts4 = 0;
    chk("start_clears_win", win, 0);
    chk("start_clears_lose", lose, 0);
  endtask
  // expects the DUT to be in ADD; leaves it in USER
  task automatic play_round();
    logic [NB-1:0] e;
    m_lfsr = step(m_lfsr);
    seq.push_back(int'(m_lfsr[1:0]));
    m_round++;
    foreach (seq[i]) q_leds.push_back(NB'(1) << seq[i]);
    cyc();
    chk("round", round, m_round);
    chk("round4", round4, m_round);
    chk("match_idle", match, 0);
    while (q_leds.size() > 0) begin
      e = q_leds.pop_front();
      chk("show", show, 1);
      chk("leds_on", leds, e);
      chk("leds4_on", leds4, e);
      for (int t = 0; t < ON; t++) begin
        cyc();
        chk("leds_hold", leds, e);
        tk();
      end
      chk("leds_off", leds, 0);
      for (int t = 0; t < OFF; t++) begin
        cyc();
        chk("dark_hold", leds, 0);
        tk();
      end
    end
    chk("user", user, 1);
    chk("user4", user4, 1);
    chk("show_end", show, 0);
  endtask
  task automatic press_round();
    logic m;
    foreach (seq[i]) begin
      btn = NB'(1) << seq[i];
      q_match.push_back(1'b1);
      cyc();
      btn = '0;
      m = q_match.pop_front();
      chk("match", match, m);
      chk("match4", match4, m);
    end
    m_pts = m_pts + m_round > 255 ? 255 : m_pts + m_round;
    m_pts4 = m_pts4 + m_round > 15 ? 15 : m_pts4 + m_round;
    chk("points", points, m_pts);
    chk("points4", points4, m_pts4);
    chk("no_lose", lose, 0);
  endtask
  task automatic play_game(input logic [15:0] s, input int tl, input int rounds);
    new_game(s, tl);
    repeat (rounds) begin
      play_round();
      press_round();
    end
    chk("win", win, 1);
    chk("win4", win4, 1);
    chk("win_leds", leds, 0);
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_leds", leds, 0);
    chk("rst_round", round, 0);
    chk("rst_points", points, 0);
    chk("rst_flags", {show, user, match, win, lose}, 0);
    chk("rst_lfsr", u8.lfsr, 16'hACE1);
    R = 1'b0;
    cyc();
    btn = 4'b0001;
    tk();
    btn = '0;
    chk("idle_ignores", {show, user, match, leds}, 0);
    play_game(16'h0000, 2, 2);
    chk("mem0", u8.mem[0], 0);
    chk("lfsr_r2", u8.lfsr, 16'h7138);
    new_game(16'h0000, 2);
    play_round();
    btn = 4'b0010;
    q_match.push_back(1'b0);
    cyc();
    btn = '0;
    chk("wrong_match", match, q_match.pop_front());
    chk("wrong_lose", lose, 1);
    chk("wrong_user", user, 0);
    new_game(16'h0000, 2);
    play_round();
    btn = 4'b0011;
    q_match.push_back(1'b0);
    cyc();
    btn = '0;
    chk("multi_match", match, q_match.pop_front());
    chk("multi_lose", lose, 1);
    chk("lose_leds", leds, 0);
    new_game(16'h0000, 2);
    play_round();
    repeat (TO - 1) tk();
    chk("tmo_early_lose", lose, 0);
    chk("tmo_early_user", user, 1);
    tk();
    chk("tmo_lose", lose, 1);
    new_game(16'h0000, 2);
    play_round();
    repeat (TO - 1) tk();
    btn = NB'(1) << seq[0];
    tick = 1'b1;
    q_match.push_back(1'b1);
    cyc();
    btn = '0;
    tick = 1'b0;
    chk("press_beats_tmo", match, q_match.pop_front());
    chk("press_no_lose", lose, 0);
    chk("press_pts", points, 1);
    new_game(16'h1234, 3);
    cyc();
    tk();
    chk("pre_rst_show", show, 1);
    R = 1'b1;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_round", round, 0);
    chk("arst_flags", {show, user, match, win, lose}, 0);
    chk("arst_state", 32'(u8.state), 0);
    chk("arst_lfsr", u8.lfsr, 16'hACE1);
    cyc();
    R = 1'b0;
    cyc();
    play_game(16'h0000, 0, ML);
    chk("full_round", round, ML);
    chk("full_points", points, 136);
    chk("full_points4", points4, 15);
    play_game(16'hBEEF, 6, 6);
    chk("six_points", points, 21);
    chk("six_points4", points4, 15);
    new_game(16'h0000, 2);
    cyc();
    chk("restart_round", round, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
